// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: drives a req/ack data bus for loads/stores,
// formats load data, stalls upstream while a bus access is outstanding, registers MEM/WB.
module mem_access_stage #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rd_m,
    input  logic [SIZE-1:0] data2_m,
    input  logic [SIZE-1:0] imm_m,
    input  logic [SIZE-1:0] alu_result_m,
    input  logic            memwrite_m,
    input  logic            regwrite_m,
    input  logic [1:0]      wb_src_m,
    input  logic [SIZE-1:0] pcplus4_m,
    input  logic [1:0]      data_size_m,
    input  logic            ext_type_m,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [SIZE-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            stall,
    output logic [4:0]      rd_w,
    output logic            regwrite_w,
    output logic [1:0]      wb_src_w,
    output logic [SIZE-1:0] alu_result_w,
    output logic [SIZE-1:0] pcplus4_w,
    output logic [SIZE-1:0] imm_w,
    output logic [SIZE-1:0] load_data_w,
    output logic            misalign_err,
    output logic            bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUS} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d, we_q, we_d;
    logic [SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [4:0]      rd_q, rd_d;
    logic            rw_q, rw_d;
    logic [1:0]      src_q, src_d;
    logic [SIZE-1:0] alu_q, alu_d, pc_q, pc_d, imm_q, imm_d, ld_q, ld_d;
    logic            mis_q, mis_d, berr_q, berr_d;
    logic            stall_c;

    logic            mem_op, misalign;
    logic [1:0]      boff;
    logic [SIZE-1:0] rshift, ld_fmt, wd_fmt;
    logic [3:0]      ws_fmt;

    assign boff     = alu_result_m[1:0];
    assign mem_op   = memwrite_m | (regwrite_m & (wb_src_m == 2'b01));
    assign misalign = mem_op & (((data_size_m == 2'b01) & boff[0]) |
                                (data_size_m[1] & (boff != 2'b00)));
    assign rshift   = mem_rdata >> {boff, 3'b000};

    always_comb begin
        ld_fmt = mem_rdata;
        wd_fmt = data2_m;
        ws_fmt = 4'hF;
        case (data_size_m)
            2'b00: begin
                ld_fmt = ext_type_m ? {{(SIZE-8){1'b0}}, rshift[7:0]}
                                    : {{(SIZE-8){rshift[7]}}, rshift[7:0]};
                wd_fmt = {4{data2_m[7:0]}};
                ws_fmt = 4'b0001 << boff;
            end
            2'b01: begin
                ld_fmt = ext_type_m ? {{(SIZE-16){1'b0}}, rshift[15:0]}
                                    : {{(SIZE-16){rshift[15]}}, rshift[15:0]};
                wd_fmt = {2{data2_m[15:0]}};
                ws_fmt = 4'b0011 << boff;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        src_d   = src_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        ld_d    = ld_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                rd_d  = rd_m;
                rw_d  = regwrite_m;
                src_d = wb_src_m;
                alu_d = alu_result_m;
                pc_d  = pcplus4_m;
                imm_d = imm_m;
                if (misalign) begin
                    rw_d  = 1'b0;
                    mis_d = 1'b1;
                end else if (mem_op) begin
                    // Bubble into WB while the bus access is outstanding
                    rw_d    = 1'b0;
                    stall_c = 1'b1;
                    state_d = BUS;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memwrite_m;
                    addr_d  = {alu_result_m[SIZE-1:2], 2'b00};
                    wdata_d = memwrite_m ? wd_fmt : '0;
                    wstrb_d = memwrite_m ? ws_fmt : 4'h0;
                end
            end
            BUS: begin
                if (mem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                    rd_d    = rd_m;
                    rw_d    = mem_ack ? regwrite_m : 1'b0;
                    src_d   = wb_src_m;
                    alu_d   = alu_result_m;
                    pc_d    = pcplus4_m;
                    imm_d   = imm_m;
                    ld_d    = mem_ack ? ld_fmt : ld_q;
                    berr_d  = ~mem_ack;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            src_q   <= 2'b00;
            alu_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            src_q   <= src_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Stall is combinational, so gate it with reset to keep every output low during reset
    assign stall        = rst & stall_c;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign rd_w         = rd_q;
    assign regwrite_w   = rw_q;
    assign wb_src_w     = src_q;
    assign alu_result_w = alu_q;
    assign pcplus4_w    = pc_q;
    assign imm_w        = imm_q;
    assign load_data_w  = ld_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a bus responder with programmable wait states,
// one expected retirement pushed per issued instruction and popped when it reaches MEM/WB.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_m;
    logic [31:0] data2_m, imm_m, alu_result_m, pcplus4_m;
    logic        memwrite_m, regwrite_m, ext_type_m;
    logic [1:0]  wb_src_m, data_size_m;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        stall;
    logic [4:0]  rd_w;
    logic        regwrite_w, misalign_err, bus_err;
    logic [1:0]  wb_src_w;
    logic [31:0] alu_result_w, pcplus4_w, imm_w, load_data_w;

    always #5 clk = ~clk;

    mem_access_stage #(.SIZE(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rd_m(rd_m), .data2_m(data2_m), .imm_m(imm_m), .alu_result_m(alu_result_m),
        .memwrite_m(memwrite_m), .regwrite_m(regwrite_m), .wb_src_m(wb_src_m),
        .pcplus4_m(pcplus4_m), .data_size_m(data_size_m), .ext_type_m(ext_type_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .wb_src_w(wb_src_w),
        .alu_result_w(alu_result_w), .pcplus4_w(pcplus4_w), .imm_w(imm_w),
        .load_data_w(load_data_w), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d2, imm, alu, pc;
        logic        mw, rw, ext;
        logic [1:0]  src, sz;
    } op_t;

    typedef struct {
        logic        rw, mis, berr, ck_ld, ck_bus, we;
        logic [31:0] ld, addr, wdata;
        logic [3:0]  wstrb;
        int          stalls, reqs;
    } exp_t;

    typedef struct { op_t o; exp_t e; } sb_t;
    sb_t sb[$];

    // Bus responder: acks after cfg_waits request cycles, or never when cfg_noack is set
    int          cfg_waits = 0;
    bit          cfg_noack = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          wleft = 0;
    int          req_cnt = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;

    always @(negedge clk) begin
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_req) begin
            req_cnt++;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_wstrb = mem_wstrb;
            cap_we    = mem_we;
            if (!cfg_noack && wleft == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = cfg_rdata;
            end else begin
                mem_ack = 1'b0;
                wleft--;
            end
        end else begin
            mem_ack = 1'b0;
            wleft   = cfg_waits;
        end
    end

    function automatic op_t mk_op(input logic [4:0] rd, input logic [31:0] d2, input logic [31:0] alu,
                                  input logic mw, input logic rw, input logic [1:0] src,
                                  input logic [1:0] sz, input logic ext);
        op_t o;
        o.rd = rd; o.d2 = d2; o.alu = alu; o.mw = mw; o.rw = rw;
        o.src = src; o.sz = sz; o.ext = ext;
        o.imm = 32'h0BAD_0000 ^ {27'd0, rd};
        o.pc  = alu + 32'd4;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic rw, input logic mis, input logic berr,
                                    input int stalls, input int reqs,
                                    input logic ck_ld, input logic [31:0] ld,
                                    input logic ck_bus, input logic we, input logic [31:0] addr,
                                    input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_t e;
        e.rw = rw; e.mis = mis; e.berr = berr; e.stalls = stalls; e.reqs = reqs;
        e.ck_ld = ck_ld; e.ld = ld; e.ck_bus = ck_bus; e.we = we;
        e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    task automatic drive(input op_t o);
        rd_m = o.rd; data2_m = o.d2; imm_m = o.imm; alu_result_m = o.alu; pcplus4_m = o.pc;
        memwrite_m = o.mw; regwrite_m = o.rw; wb_src_m = o.src;
        data_size_m = o.sz; ext_type_m = o.ext;
    endtask

    task automatic drive_nop();
        rd_m = 5'd0; data2_m = '0; imm_m = '0; alu_result_m = '0; pcplus4_m = '0;
        memwrite_m = 1'b0; regwrite_m = 1'b0; wb_src_m = 2'b00;
        data_size_m = 2'b00; ext_type_m = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires the instruction
    task automatic issue(input string nm, input op_t o, input int waits, input bit noack,
                         input logic [31:0] rdata, input exp_t e);
        sb_t s;
        int  base, stalls, cyc;
        bit  done;
        cfg_waits = waits; cfg_noack = noack; cfg_rdata = rdata;
        drive(o);
        s.o = o; s.e = e;
        sb.push_back(s);
        base = req_cnt; stalls = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk); #1;
            if (stall) stalls++;
            else done = 1'b1;
            cyc++;
        end
        chk({nm, ".retire"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        s = sb.pop_front();
        chk({nm, ".rd_w"},       32'(rd_w),         32'(s.o.rd));
        chk({nm, ".regwrite_w"}, 32'(regwrite_w),   32'(s.e.rw));
        chk({nm, ".wb_src_w"},   32'(wb_src_w),     32'(s.o.src));
        chk({nm, ".alu_w"},      alu_result_w,      s.o.alu);
        chk({nm, ".pc_w"},       pcplus4_w,         s.o.pc);
        chk({nm, ".imm_w"},      imm_w,             s.o.imm);
        chk({nm, ".misalign"},   32'(misalign_err), 32'(s.e.mis));
        chk({nm, ".bus_err"},    32'(bus_err),      32'(s.e.berr));
        chk({nm, ".stalls"},     32'(stalls),       32'(s.e.stalls));
        chk({nm, ".req_cycles"}, 32'(req_cnt - base), 32'(s.e.reqs));
        if (s.e.ck_ld) chk({nm, ".load_data"}, load_data_w, s.e.ld);
        if (s.e.ck_bus) begin
            chk({nm, ".addr"},  cap_addr,       s.e.addr);
            chk({nm, ".we"},    32'(cap_we),    32'(s.e.we));
            chk({nm, ".wstrb"}, 32'(cap_wstrb), 32'(s.e.wstrb));
            if (s.e.we) chk({nm, ".wdata"}, cap_wdata, s.e.wdata);
        end
        drive_nop();
    endtask

    initial begin
        op_t o;
        rst = 1'b0;
        drive_nop();
        #12;
        chk("rst.mem_req",    32'(mem_req),    32'd0);
        chk("rst.stall",      32'(stall),      32'd0);
        chk("rst.regwrite_w", 32'(regwrite_w), 32'd0);
        chk("rst.alu_w",      alu_result_w,    32'd0);
        chk("rst.bus_err",    32'(bus_err),    32'd0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        issue("alu",  mk_op(5'd5, 32'h0, 32'h1234, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0), 0, 1'b0, 32'h0,
              mk_exp(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
        issue("lb",   mk_op(5'd6, 32'h0, 32'h103, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0), 1, 1'b0, 32'h80FF_FF00,
              mk_exp(1'b1, 1'b0, 1'b0, 2, 2, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0));
        issue("lbu",  mk_op(5'd7, 32'h0, 32'h103, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1), 0, 1'b0, 32'h80FF_FF00,
              mk_exp(1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0));
        issue("sh",   mk_op(5'd0, 32'h0000_ABCD, 32'h202, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0), 3, 1'b0, 32'h0,
              mk_exp(1'b0, 1'b0, 1'b0, 4, 4, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD));
        issue("lw_mis", mk_op(5'd8, 32'h0, 32'h101, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0), 0, 1'b0, 32'h0,
              mk_exp(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
        issue("lh",   mk_op(5'd9, 32'h0, 32'h102, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0), 2, 1'b0, 32'h8001_1234,
              mk_exp(1'b1, 1'b0, 1'b0, 3, 3, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0));
        issue("lhu",  mk_op(5'd10, 32'h0, 32'h100, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1), 0, 1'b0, 32'h8001_1234,
              mk_exp(1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0));
        issue("sb",   mk_op(5'd0, 32'h1234_565A, 32'h201, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0), 1, 1'b0, 32'h0,
              mk_exp(1'b0, 1'b0, 1'b0, 2, 2, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 4'b0010, 32'h5A5A_5A5A));
        issue("sw",   mk_op(5'd0, 32'hDEAD_BEEF, 32'h300, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0), 0, 1'b0, 32'h0,
              mk_exp(1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 4'hF, 32'hDEAD_BEEF));
        issue("lw11", mk_op(5'd11, 32'h0, 32'h304, 1'b0, 1'b1, 2'b01, 2'b11, 1'b0), 1, 1'b0, 32'hCAFE_F00D,
              mk_exp(1'b1, 1'b0, 1'b0, 2, 2, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h304, 4'h0, 32'h0));
        issue("sh_mis", mk_op(5'd0, 32'h1111, 32'h203, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0), 0, 1'b0, 32'h0,
              mk_exp(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
        issue("lw_tmo", mk_op(5'd12, 32'h0, 32'h400, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0), 0, 1'b1, 32'h0,
              mk_exp(1'b0, 1'b0, 1'b1, 16, 16, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0));
        for (int i = 0; i < 4; i++) begin
            o = mk_op(5'($urandom_range(1, 31)), $urandom, $urandom, 1'b0, 1'b1, 2'($urandom_range(0, 3) & 2), 2'b10, 1'b0);
            issue("alu_rnd", o, 0, 1'b0, 32'h0,
                  mk_exp(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
        end

        // Reset in the middle of an unacknowledged load
        cfg_noack = 1'b1;
        drive(mk_op(5'd13, 32'h0, 32'h500, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0));
        repeat (4) @(negedge clk);
        chk("mid.req_before", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid.mem_req",    32'(mem_req),    32'd0);
        chk("mid.stall",      32'(stall),      32'd0);
        chk("mid.mem_addr",   mem_addr,        32'd0);
        chk("mid.rd_w",       32'(rd_w),       32'd0);
        chk("mid.regwrite_w", 32'(regwrite_w), 32'd0);
        chk("mid.load_data",  load_data_w,     32'd0);
        drive_nop();
        cfg_noack = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        issue("post_rst", mk_op(5'd14, 32'h0, 32'h4321, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0), 0, 1'b0, 32'h0,
              mk_exp(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
